// File: rtl/adc_err_avg_fx.sv
// ADC-to-error front end: edge-captures ADC samples, averages 2^AVG_LOG2 of them,
// and emits a saturated signed error vref - average with a one-cycle ready pulse.
module adc_err_avg_fx #(
  parameter int unsigned ADC_W    = 12,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned OUT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    adc_ready,
  input  logic [ADC_W-1:0]        adc,
  input  logic signed [OUT_W-1:0] vref,
  output logic signed [OUT_W-1:0] e0,
  output logic                    e0_ready,
  output logic                    e0_sat,
  output logic                    overrun
);

  localparam int unsigned ACC_W  = ADC_W + AVG_LOG2;
  localparam int unsigned CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned DIFF_W = OUT_W + 1;
  // With AVG_LOG2=0 the last count is 0, so every sample completes an average.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [OUT_W-1:0] E0_MAX   = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] E0_MIN   = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ACC = 2'd0,
    SUB = 2'd1,
    OUT = 2'd2
  } state_t;

  state_t                    state, state_nxt;
  logic [ACC_W-1:0]          acc, acc_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic signed [DIFF_W-1:0]  diff, diff_nxt;
  logic                      adc_ready_d;
  logic signed [OUT_W-1:0]   e0_nxt;
  logic                      e0_sat_nxt;
  logic                      e0_ready_nxt;
  logic                      overrun_nxt;

  logic                      sample_edge_c;
  logic [ADC_W-1:0]          avg_c;
  logic signed [DIFF_W-1:0]  sub_c;
  logic                      clip_c;
  logic signed [OUT_W-1:0]   sat_val_c;

  assign sample_edge_c = adc_ready & ~adc_ready_d;

  // Floor average; it always fits back into ADC_W bits.
  assign avg_c = ADC_W'(acc >> AVG_LOG2);
  assign sub_c = $signed({vref[OUT_W-1], vref}) - $signed(DIFF_W'(avg_c));

  // Result overflows OUT_W exactly when the two top bits of diff disagree.
  assign clip_c    = diff[DIFF_W-1] ^ diff[DIFF_W-2];
  assign sat_val_c = clip_c ? (diff[DIFF_W-1] ? E0_MIN : E0_MAX) : diff[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ACC;
      acc         <= '0;
      cnt         <= '0;
      diff        <= '0;
      adc_ready_d <= 1'b0;
      e0          <= '0;
      e0_sat      <= 1'b0;
      e0_ready    <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_nxt;
      acc         <= acc_nxt;
      cnt         <= cnt_nxt;
      diff        <= diff_nxt;
      adc_ready_d <= adc_ready;
      e0          <= e0_nxt;
      e0_sat      <= e0_sat_nxt;
      e0_ready    <= e0_ready_nxt;
      overrun     <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    acc_nxt      = acc;
    cnt_nxt      = cnt;
    diff_nxt     = diff;
    e0_nxt       = e0;
    e0_sat_nxt   = e0_sat;
    e0_ready_nxt = 1'b0;
    overrun_nxt  = 1'b0;

    if (!en) begin
      // Disable abandons any partial average or pending result.
      state_nxt = ACC;
      acc_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ACC: begin
          if (sample_edge_c) begin
            acc_nxt = acc + ACC_W'(adc);
            if (cnt == CNT_LAST) begin
              cnt_nxt   = '0;
              state_nxt = SUB;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
        end
        SUB: begin
          diff_nxt    = sub_c;
          acc_nxt     = '0;
          overrun_nxt = sample_edge_c;
          state_nxt   = OUT;
        end
        OUT: begin
          e0_nxt       = sat_val_c;
          e0_sat_nxt   = clip_c;
          e0_ready_nxt = 1'b1;
          overrun_nxt  = sample_edge_c;
          state_nxt    = ACC;
        end
        default: state_nxt = ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_err_avg_fx.sv
// Directed bench for adc_err_avg_fx: three parameterisations share clk/rst/en.
module tb_adc_err_avg_fx;

  logic clk = 1'b0;
  logic rst;
  logic en;

  // A: AVG_LOG2=0, OUT_W=16
  logic               a_rdy;
  logic [11:0]        a_adc;
  logic signed [15:0] a_vref;
  logic signed [15:0] a_e0;
  logic               a_e0_ready, a_e0_sat, a_ovr;
  // B: AVG_LOG2=2, OUT_W=16
  logic               b_rdy;
  logic [11:0]        b_adc;
  logic signed [15:0] b_vref;
  logic signed [15:0] b_e0;
  logic               b_e0_ready, b_e0_sat, b_ovr;
  // C: AVG_LOG2=0, OUT_W=13
  logic               c_rdy;
  logic [11:0]        c_adc;
  logic signed [12:0] c_vref;
  logic signed [12:0] c_e0;
  logic               c_e0_ready, c_e0_sat, c_ovr;

  int checks = 0;
  int errors = 0;
  int b_rdy_n = 0;
  int b_ovr_n = 0;
  int base;

  always #5 clk = ~clk;

  adc_err_avg_fx #(.ADC_W(12), .AVG_LOG2(0), .OUT_W(16)) u_a (
    .clk(clk), .rst(rst), .en(en), .adc_ready(a_rdy), .adc(a_adc), .vref(a_vref),
    .e0(a_e0), .e0_ready(a_e0_ready), .e0_sat(a_e0_sat), .overrun(a_ovr));

  adc_err_avg_fx #(.ADC_W(12), .AVG_LOG2(2), .OUT_W(16)) u_b (
    .clk(clk), .rst(rst), .en(en), .adc_ready(b_rdy), .adc(b_adc), .vref(b_vref),
    .e0(b_e0), .e0_ready(b_e0_ready), .e0_sat(b_e0_sat), .overrun(b_ovr));

  adc_err_avg_fx #(.ADC_W(12), .AVG_LOG2(0), .OUT_W(13)) u_c (
    .clk(clk), .rst(rst), .en(en), .adc_ready(c_rdy), .adc(c_adc), .vref(c_vref),
    .e0(c_e0), .e0_ready(c_e0_ready), .e0_sat(c_e0_sat), .overrun(c_ovr));

  always @(negedge clk) begin
    if (b_e0_ready === 1'b1) b_rdy_n <= b_rdy_n + 1;
    if (b_ovr === 1'b1)      b_ovr_n <= b_ovr_n + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One-cycle strobe on B, then idle so samples are 5 cycles apart.
  task automatic b_sample(input logic [11:0] v);
    b_adc = v;
    b_rdy = 1'b1;
    tick();
    b_rdy = 1'b0;
    repeat (4) tick();
  endtask

  task automatic a_sample(input logic [11:0] v);
    a_adc = v;
    a_rdy = 1'b1;
    tick();
    a_rdy = 1'b0;
    repeat (4) tick();
  endtask

  task automatic c_sample(input logic [11:0] v);
    c_adc = v;
    c_rdy = 1'b1;
    tick();
    c_rdy = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1;
    a_rdy = 1'b0; a_adc = '0; a_vref = '0;
    b_rdy = 1'b0; b_adc = '0; b_vref = '0;
    c_rdy = 1'b0; c_adc = '0; c_vref = '0;
    repeat (2) tick();
    chk("rst_a_e0", a_e0, 0);
    chk("rst_a_ready", a_e0_ready, 0);
    chk("rst_b_e0", b_e0, 0);
    chk("rst_b_sat", b_e0_sat, 0);
    chk("rst_c_ovr", c_ovr, 0);
    rst = 1'b0;
    tick();

    // No averaging: 2000 - 1500, pulse exactly two edges after capture
    a_vref = 16'sd2000; a_adc = 12'd1500; a_rdy = 1'b1;
    tick();
    chk("a_lat0", a_e0_ready, 0);
    a_rdy = 1'b0;
    tick();
    chk("a_lat1", a_e0_ready, 0);
    tick();
    chk("a_lat2_ready", a_e0_ready, 1);
    chk("a_e0", a_e0, 500);
    chk("a_sat", a_e0_sat, 0);
    tick();
    chk("a_lat3", a_e0_ready, 0);
    chk("a_hold", a_e0, 500);

    // Narrow output: negative clip, then exact positive bound
    c_vref = -13'sd4096;
    c_sample(12'd4095);
    chk("c_neg_e0", c_e0, -4096);
    chk("c_neg_sat", c_e0_sat, 1);
    c_vref = 13'sd4095;
    c_sample(12'd0);
    chk("c_pos_e0", c_e0, 4095);
    chk("c_pos_sat", c_e0_sat, 0);

    // Four-sample average
    base = b_rdy_n;
    b_vref = 16'sd1000;
    b_sample(12'd100); b_sample(12'd200); b_sample(12'd300);
    chk("b_no_early", b_rdy_n - base, 0);
    b_sample(12'd400);
    chk("b_one_ready", b_rdy_n - base, 1);
    chk("b_avg_e0", b_e0, 750);
    b_vref = 16'sd0;
    b_sample(12'd1); b_sample(12'd1); b_sample(12'd1); b_sample(12'd2);
    chk("b_floor_e0", b_e0, -1);
    chk("b_floor_sat", b_e0_sat, 0);

    // Held level yields one sample: 100,200,300,400 -> 250
    base = b_rdy_n;
    b_vref = 16'sd500; b_adc = 12'd100; b_rdy = 1'b1;
    repeat (10) tick();
    b_rdy = 1'b0;
    tick();
    b_sample(12'd200); b_sample(12'd300);
    chk("held_no_early", b_rdy_n - base, 0);
    b_sample(12'd400);
    chk("held_ready", b_rdy_n - base, 1);
    chk("held_e0", b_e0, 250);

    // Overrun: edge lands while in OUT
    base = b_ovr_n;
    b_vref = 16'sd0;
    b_sample(12'd10); b_sample(12'd10); b_sample(12'd10);
    b_adc = 12'd10; b_rdy = 1'b1;
    tick();
    b_rdy = 1'b0;
    tick();
    b_adc = 12'd999; b_rdy = 1'b1;
    tick();
    chk("ovr_pulse", b_ovr, 1);
    chk("ovr_ready", b_e0_ready, 1);
    chk("ovr_e0", b_e0, -10);
    b_rdy = 1'b0;
    tick();
    chk("ovr_low", b_ovr, 0);
    repeat (3) tick();
    chk("ovr_count", b_ovr_n - base, 1);
    chk("ovr_e0_hold", b_e0, -10);
    b_sample(12'd20); b_sample(12'd20); b_sample(12'd20); b_sample(12'd20);
    chk("ovr_after_e0", b_e0, -20);

    // Reset mid-accumulation discards partial average
    base = b_rdy_n;
    b_vref = 16'sd100;
    b_sample(12'd900); b_sample(12'd900);
    rst = 1'b1;
    tick();
    chk("midrst_e0", b_e0, 0);
    rst = 1'b0;
    tick();
    b_sample(12'd50); b_sample(12'd50); b_sample(12'd50);
    chk("midrst_no_early", b_rdy_n - base, 0);
    b_sample(12'd50);
    chk("midrst_ready", b_rdy_n - base, 1);
    chk("midrst_e0_val", b_e0, 50);

    // en dropped while SUB is active
    base = b_rdy_n;
    b_vref = 16'sd0;
    b_sample(12'd8); b_sample(12'd8); b_sample(12'd8);
    b_adc = 12'd8; b_rdy = 1'b1;
    tick();
    en = 1'b0; b_rdy = 1'b0;
    tick();
    en = 1'b1;
    repeat (4) tick();
    chk("en_no_ready", b_rdy_n - base, 0);
    chk("en_e0_hold", b_e0, 50);
    b_vref = 16'sd100;
    b_sample(12'd60); b_sample(12'd60); b_sample(12'd60); b_sample(12'd64);
    chk("en_resume_ready", b_rdy_n - base, 1);
    chk("en_resume_e0", b_e0, 39);

    // Sanity on A after the shared reset
    a_vref = 16'sd10;
    a_sample(12'd30);
    chk("a_neg_e0", a_e0, -20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
